// File: rtl/uart_time_pkg.sv
// Shared types and constants for the UART time-set frame parser.
package uart_time_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIELD,
    EOL,
    CHECK,
    COMMIT,
    ERR
  } state_t;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] ACK_OK   = 8'h4B;
  localparam logic [7:0] ACK_ERR  = 8'h45;

  localparam logic [6:0] HOUR_MAX    = 7'd24;
  localparam logic [6:0] MIN_SEC_MAX = 7'd60;

  // Two BCD-style digits to binary without a multiplier: t*10 = t*8 + t*2.
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII digit classifier: byte -> {is_digit, value}.
module ascii_digit_decode
  import uart_time_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] value
);

  assign is_digit = (ch >= CH_0) && (ch <= CH_9);
  // Only meaningful when is_digit is set; low nibble of the offset suffices.
  assign value    = 4'(ch - CH_0);

endmodule

// File: rtl/uart_time_parser.sv
// Parses "T HH:MM:SS EOL" frames popped from the RX FIFO into hour/minute/
// second set values, pulsing set_valid on a good frame and frame_err on a
// malformed, out-of-range or timed-out one.
// Optional feature: define UART_TIME_PARSER_ACK_EN to add a TX acknowledge
// ('K' on commit, 'E' on error) through a one-entry pending register.
module uart_time_parser
  import uart_time_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_TICKS = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_100hz,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_empty,
  output logic                  rx_re,
  output logic [4:0]            set_hour,
  output logic [5:0]            set_min,
  output logic [5:0]            set_sec,
  output logic                  set_valid,
  output logic                  frame_err,
  output logic                  busy
`ifdef UART_TIME_PARSER_ACK_EN
  ,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_we,
  input  logic                  tx_full
`endif
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_TICKS - 1);

  state_t     state;
  logic [2:0] pos;
  logic [7:0] idle_cnt;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [7:0] rx_byte;
  logic       is_digit;
  logic [3:0] digit;
  logic       field_ok;
  logic       timeout_hit;
  logic       ack_hold;
  logic [6:0] hour_v, min_v, sec_v;

  assign rx_byte = rx_data[7:0];

  ascii_digit_decode u_digit (
    .ch       (rx_byte),
    .is_digit (is_digit),
    .value    (digit)
  );

  // Positions 2 and 5 are the colon separators, all others are digits.
  assign field_ok = ((pos == 3'd2) || (pos == 3'd5)) ? (rx_byte == CH_COLON) : is_digit;

  assign hour_v = bcd_to_bin(h1, h0);
  assign min_v  = bcd_to_bin(m1, m0);
  assign sec_v  = bcd_to_bin(s1, s0);

  // Pop is gated by reset so bytes waiting during reset are parsed afterwards.
  assign rx_re = rst && !rx_empty && !ack_hold && (state inside {IDLE, FIELD, EOL});

  // A pop in the same cycle as a tick clears the counter, so it never times out.
  assign timeout_hit = tick_100hz && !rx_re && (idle_cnt >= TIMEOUT_LIM);

  assign busy = (state != IDLE);

  // Frame FSM with idle timeout and registered commit/error outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pos       <= 3'd0;
      idle_cnt  <= 8'd0;
      set_hour  <= 5'd0;
      set_min   <= 6'd0;
      set_sec   <= 6'd0;
      set_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      set_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= 8'd0;
          if (rx_re && (rx_byte == CH_T)) begin
            state <= FIELD;
            pos   <= 3'd0;
          end
        end
        FIELD, EOL: begin
          if (rx_re) begin
            idle_cnt <= 8'd0;
          end else if (tick_100hz) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
          if (rx_re) begin
            if (state == FIELD) begin
              pos <= pos + 3'd1;
              if (!field_ok) begin
                state     <= ERR;
                frame_err <= 1'b1;
              end else if (pos == 3'd7) begin
                state <= EOL;
              end
            end else if ((rx_byte == CH_LF) || (rx_byte == CH_CR)) begin
              state <= CHECK;
            end else begin
              state     <= ERR;
              frame_err <= 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= ERR;
            frame_err <= 1'b1;
          end
        end
        CHECK: begin
          idle_cnt <= 8'd0;
          if ((hour_v >= HOUR_MAX) || (min_v >= MIN_SEC_MAX) || (sec_v >= MIN_SEC_MAX)) begin
            state     <= ERR;
            frame_err <= 1'b1;
          end else begin
            state     <= COMMIT;
            set_valid <= 1'b1;
            set_hour  <= hour_v[4:0];
            set_min   <= min_v[5:0];
            set_sec   <= sec_v[5:0];
          end
        end
        default: begin
          idle_cnt <= 8'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Digit capture; these are pure data and need no reset.
  always_ff @(posedge clk) begin
    if ((state == FIELD) && rx_re) begin
      case (pos)
        3'd0:    h1 <= digit;
        3'd1:    h0 <= digit;
        3'd3:    m1 <= digit;
        3'd4:    m0 <= digit;
        3'd6:    s1 <= digit;
        3'd7:    s0 <= digit;
        default: ;
      endcase
    end
  end

`ifdef UART_TIME_PARSER_ACK_EN
  logic       ack_pend;
  logic [7:0] ack_byte;

  assign ack_hold = ack_pend;
  assign tx_we    = ack_pend && !tx_full;
  assign tx_data  = DATA_WIDTH'(ack_byte);

  // One-entry ack buffer: filled on COMMIT/ERR, drained when TX has room.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_pend <= 1'b0;
      ack_byte <= 8'h00;
    end else begin
      if (tx_we) begin
        ack_pend <= 1'b0;
      end
      if ((state == COMMIT) || (state == ERR)) begin
        ack_pend <= 1'b1;
        ack_byte <= (state == COMMIT) ? ACK_OK : ACK_ERR;
      end
    end
  end
`else
  assign ack_hold = 1'b0;
`endif

endmodule

// File: doc/uart_time_parser.md
# uart_time_parser

Receive-side ASCII command decoder that turns a time-set frame from the PC into binary hour/minute/second values for the watch. It sits between the RX read port of UART_FIFO and the set inputs of the watch/stopwatch block. It performs the inverse of the time-to-ASCII encoding on the TX path. It pops bytes with a show-ahead read handshake, validates the frame `T HH ':' MM ':' SS EOL`, and issues a one-cycle commit or error pulse.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of the FIFO data.
- TIMEOUT_TICKS, 50, number of tick_100hz periods allowed between bytes inside a frame (50 = 0.5 s).

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
  - clk  in  1  system clock.
  - rst  in  1  synchronous, active-low reset.
- Inputs:
  - tick_100hz  in  1  one-cycle strobe at 100 Hz.
  - rx_data  in  DATA_WIDTH  FIFO head byte; valid whenever rx_empty=0.
  - rx_empty  in  1  RX FIFO empty.
- Outputs:
  - rx_re  out  1  pop strobe; the head byte is consumed in the same cycle.
  - set_hour  out  5  last committed hour, 0..23.
  - set_min  out  6  last committed minute, 0..59.
  - set_sec  out  6  last committed second, 0..59.
  - set_valid  out  1  one-cycle commit pulse.
  - frame_err  out  1  one-cycle error pulse.
  - busy  out  1  high while a frame is in progress.

## Operation
- States:
  - IDLE: waiting for 'T'.
  - FIELD: position counter pos runs 0..7 over H1 H0 ':' M1 M0 ':' S1 S0.
  - EOL: waiting for the end-of-line byte.
  - CHECK: range check.
  - COMMIT: update outputs and pulse set_valid.
  - ERR: pulse frame_err.
- Byte consumption:
  - rx_re = !rx_empty && state ∈ {IDLE, FIELD, EOL}.
  - At most one byte is consumed per cycle.
- IDLE:
  - 0x54 'T' → FIELD with pos=0.
  - Any other byte is popped and discarded with no error.
- FIELD:
  - pos 0,1,3,4,6,7 require '0'..'9' (0x30–0x39). The digit value is rx_data−0x30, stored in a 4-bit register.
  - pos 2,5 require ':' (0x3A).
  - Any mismatch → ERR; the offending byte is consumed.
  - After pos 7 → EOL.
- EOL:
  - 0x0A or 0x0D → CHECK.
  - Anything else → ERR.
- CHECK:
  - value = tens*10 + ones, computed as (t<<3)+(t<<1)+o in 7 bits.
  - hour must be <24, minute <60, second <60. Any violation → ERR; otherwise → COMMIT.
- COMMIT:
  - Load the set_* registers and assert set_valid for 1 cycle → IDLE.
- ERR:
  - Assert frame_err for 1 cycle → IDLE.
  - set_* keep their previous values.
- Timeout:
  - An 8-bit idle counter counts tick_100hz while state ∈ {FIELD, EOL}. It clears on every pop and in IDLE.
  - Reaching TIMEOUT_TICKS → ERR.
  - If a pop and a tick land in the same cycle, the pop wins (counter clears).
- busy = state ≠ IDLE.

## Timing
- Reset values: all outputs are 0, state = IDLE, counters = 0.
- Reset mid-frame aborts the frame with no error pulse. Bytes still in the FIFO are parsed fresh.
- The EOL pop happens in cycle N. CHECK occupies N+1, and set_valid or frame_err is high in N+2.
- set_* change in the same cycle set_valid rises and are stable until the next commit.
- Minimum frame time is 10 cycles of back-to-back bytes plus 2 cycles (CHECK, COMMIT/ERR).
- rx_re is low in CHECK, COMMIT and ERR, so bytes arriving then wait in the FIFO.
- rx_data is sampled only in cycles where rx_re=1.

## Configuration
- Macro: UART_TIME_PARSER_ACK_EN.
- Defined:
  - Adds ports tx_data [DATA_WIDTH-1:0] out, tx_we out, and tx_full in.
  - Each COMMIT queues 'K' (0x4B); each ERR queues 'E' (0x45).
  - The byte is held in a 1-entry pending register and written (tx_we=1 for 1 cycle) in the first cycle with tx_full=0.
  - While an ack is pending, the FSM stalls in IDLE with rx_re=0.
- Undefined: no TX ports and no ack logic.

## Structure
- Package uart_time_pkg holds:
  - the state enum;
  - ASCII constants CH_T, CH_COLON, CH_LF, CH_CR, CH_0, CH_9, ACK_OK, ACK_ERR;
  - limits HOUR_MAX=24 and MIN_SEC_MAX=60.
- One sub-module, ascii_digit_decode, is combinational: byte → {is_digit, value[3:0]}.

## Test plan
- "T12:34:56\n" back-to-back:
  - 10 rx_re pulses;
  - set_valid pulses 2 cycles after the '\n' pop;
  - set_hour=12, set_min=34, set_sec=56.
- "T25:00:00\n" after a good frame → frame_err pulse, no set_valid; set_* unchanged at 12/34/56.
- "T1a" followed by "T00:00:00\r":
  - frame_err on the 'a' pop;
  - the second frame commits 0/0/0.
- "xyz" then "T23:59:59\n" → 3 silent pops with no frame_err, then commit 23/59/59.
- TIMEOUT_TICKS=5, feed "T12:3" then stall for 5 ticks:
  - frame_err on the 5th tick;
  - busy drops;
  - a later full frame commits.
- With UART_TIME_PARSER_ACK_EN and tx_full held high for 20 cycles across a commit:
  - no tx_we while tx_full is high;
  - a single tx_we with tx_data=0x4B in the first cycle after tx_full falls;
  - rx_re stays 0 meanwhile.
